// File: rtl/vrf_pkg.sv
// Shared types and address helpers for the lane-banked vector register file.
package vrf_pkg;

  localparam int VDW_LP    = 32;
  localparam int MASK_W_LP = VDW_LP / 8;

  typedef logic [VDW_LP-1:0]    elem_t;
  typedef logic [MASK_W_LP-1:0] byte_mask_t;

  typedef enum logic [0:0] {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // Element e sits in lane e % lanes at row e / lanes.
  function automatic int unsigned row_of(input int unsigned addr, input int unsigned lane_bits);
    return addr >> lane_bits;
  endfunction

  function automatic int unsigned lane_of(input int unsigned addr, input int unsigned lanes);
    return addr % lanes;
  endfunction

endpackage

// File: rtl/vrf_lane_bank.sv
// One lane's storage: byte-masked single write port, registered read ports with write-first bypass.
module vrf_lane_bank
  import vrf_pkg::*;
#(
  parameter int els_p        = 8,
  parameter int rows_p       = 4,
  parameter int vdw_p        = VDW_LP,
  parameter int read_ports_p = 2,
  parameter int reg_aw_p     = 3,
  parameter int row_w_p      = 2,
  localparam int mask_w_lp   = vdw_p / 8
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [read_ports_p-1:0][reg_aw_p-1:0]     r_reg_addr_i,
  input  logic [read_ports_p-1:0][row_w_p-1:0]      r_row_i,
  output logic [read_ports_p-1:0][vdw_p-1:0]        r_data_o,
  input  logic                                      w_en_i,
  input  logic [reg_aw_p-1:0]                       w_reg_addr_i,
  input  logic [row_w_p-1:0]                        w_row_i,
  input  logic [vdw_p-1:0]                          w_data_i,
  input  logic [mask_w_lp-1:0]                      w_mask_i
);

  logic [vdw_p-1:0] mem_r [els_p][rows_p];
  logic [vdw_p-1:0] merged_s;

  // Post-mask value of the addressed word; feeds both storage and the read bypass.
  always_comb begin
    merged_s = mem_r[w_reg_addr_i][w_row_i];
    for (int b = 0; b < mask_w_lp; b++) begin
      if (w_mask_i[b]) begin
        merged_s[8*b +: 8] = w_data_i[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = mem_r[w_reg_addr_i][w_row_i][8*b +: 8];
      end
    end
  end

  // Storage update; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      mem_r[w_reg_addr_i][w_row_i] <= merged_s;
    end
  end

  // Registered read ports with write-first forwarding.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data_o <= '0;
    end else begin
      for (int p = 0; p < read_ports_p; p++) begin
        if (w_en_i && (r_reg_addr_i[p] == w_reg_addr_i) && (r_row_i[p] == w_row_i)) begin
          r_data_o[p] <= merged_s;
        end else begin
          r_data_o[p] <= mem_r[r_reg_addr_i[p]][r_row_i[p]];
        end
      end
    end
  end

endmodule

// File: rtl/vrf_banked.sv
// Lane-banked vector register file: multi-port registered reads, masked writes, register-clear engine.
module vrf_banked
  import vrf_pkg::*;
#(
  parameter int els_p        = 8,
  parameter int vlen_p       = 8,
  parameter int vdw_p        = VDW_LP,
  parameter int lanes_p      = 2,
  parameter int read_ports_p = 2,
  localparam int rows_lp     = vlen_p / lanes_p,
  localparam int reg_aw_lp   = $clog2(els_p),
  localparam int el_aw_lp    = $clog2(vlen_p),
  localparam int mask_w_lp   = vdw_p / 8
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_i,
  input  logic [read_ports_p-1:0][reg_aw_lp-1:0]               r_reg_addr_i,
  input  logic [read_ports_p-1:0][lanes_p-1:0][el_aw_lp-1:0]   r_addr_i,
  output logic [read_ports_p-1:0][lanes_p-1:0][vdw_p-1:0]      r_data_o,
  input  logic [reg_aw_lp-1:0]                                 w_reg_addr_i,
  input  logic [lanes_p-1:0][el_aw_lp-1:0]                     w_addr_i,
  input  logic [lanes_p-1:0][vdw_p-1:0]                        w_data_i,
  input  logic [lanes_p-1:0][mask_w_lp-1:0]                    w_mask_i,
  input  logic [lanes_p-1:0]                                   w_en_i,
  output logic                                                 w_ready_o,
  input  logic                                                 clr_v_i,
  input  logic [reg_aw_lp-1:0]                                 clr_reg_i,
  output logic                                                 clr_ready_o,
  output logic                                                 clr_done_o
);

  localparam int lane_bits_lp = $clog2(lanes_p);
  localparam int row_w_lp     = (rows_lp > 1) ? $clog2(rows_lp) : 1;

  clr_state_e              state_r, state_next_s;
  logic [reg_aw_lp-1:0]    clr_reg_r;
  logic [row_w_lp-1:0]     row_r;
  logic                    clr_done_r;
  logic                    clearing_s, last_row_s;

  logic [lanes_p-1:0]                                  bank_w_en_s;
  logic [lanes_p-1:0][reg_aw_lp-1:0]                   bank_w_reg_s;
  logic [lanes_p-1:0][row_w_lp-1:0]                    bank_w_row_s;
  logic [lanes_p-1:0][vdw_p-1:0]                       bank_w_data_s;
  logic [lanes_p-1:0][mask_w_lp-1:0]                   bank_w_mask_s;
  logic [lanes_p-1:0][read_ports_p-1:0][row_w_lp-1:0]  bank_r_row_s;
  logic [lanes_p-1:0][read_ports_p-1:0][vdw_p-1:0]     bank_r_data_s;

  assign clearing_s  = (state_r == CLR_CLEAR);
  assign last_row_s  = (row_r == row_w_lp'(rows_lp - 1));
  assign w_ready_o   = !clearing_s;
  assign clr_ready_o = !clearing_s;
  assign clr_done_o  = clr_done_r;

  // Clear FSM next-state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLR_IDLE: begin
        if (clr_v_i) begin
          state_next_s = CLR_CLEAR;
        end else begin
          state_next_s = CLR_IDLE;
        end
      end
      CLR_CLEAR: begin
        if (last_row_s) begin
          state_next_s = CLR_IDLE;
        end else begin
          state_next_s = CLR_CLEAR;
        end
      end
      default: state_next_s = CLR_IDLE;
    endcase
  end

  // Clear FSM state, target register, row counter and completion pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= CLR_IDLE;
      clr_reg_r  <= '0;
      row_r      <= '0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      clr_done_r <= clearing_s && last_row_s;
      if (!clearing_s && clr_v_i) begin
        clr_reg_r <= clr_reg_i;
        row_r     <= '0;
      end else if (clearing_s) begin
        row_r <= row_r + row_w_lp'(1);
      end
    end
  end

  // While clearing, the engine owns every lane's write port and writes a full-mask zero.
  always_comb begin
    bank_w_en_s   = '0;
    bank_w_reg_s  = '0;
    bank_w_row_s  = '0;
    bank_w_data_s = '0;
    bank_w_mask_s = '0;
    for (int l = 0; l < lanes_p; l++) begin
      if (clearing_s) begin
        bank_w_en_s[l]   = 1'b1;
        bank_w_reg_s[l]  = clr_reg_r;
        bank_w_row_s[l]  = row_r;
        bank_w_data_s[l] = '0;
        bank_w_mask_s[l] = '1;
      end else begin
        bank_w_en_s[l]   = w_en_i[l] && w_ready_o;
        bank_w_reg_s[l]  = w_reg_addr_i;
        bank_w_row_s[l]  = row_w_lp'(row_of(32'(w_addr_i[l]), lane_bits_lp));
        bank_w_data_s[l] = w_data_i[l];
        bank_w_mask_s[l] = w_mask_i[l];
      end
    end
  end

  for (genvar l = 0; l < lanes_p; l++) begin : g_lane
    for (genvar p = 0; p < read_ports_p; p++) begin : g_port
      assign bank_r_row_s[l][p] = row_w_lp'(row_of(32'(r_addr_i[p][l]), lane_bits_lp));
      assign r_data_o[p][l]     = bank_r_data_s[l][p];
    end

    vrf_lane_bank #(
      .els_p        (els_p),
      .rows_p       (rows_lp),
      .vdw_p        (vdw_p),
      .read_ports_p (read_ports_p),
      .reg_aw_p     (reg_aw_lp),
      .row_w_p      (row_w_lp)
    ) u_bank (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .r_reg_addr_i (r_reg_addr_i),
      .r_row_i      (bank_r_row_s[l]),
      .r_data_o     (bank_r_data_s[l]),
      .w_en_i       (bank_w_en_s[l]),
      .w_reg_addr_i (bank_w_reg_s[l]),
      .w_row_i      (bank_w_row_s[l]),
      .w_data_i     (bank_w_data_s[l]),
      .w_mask_i     (bank_w_mask_s[l])
    );
  end

endmodule

// File: tb/tb_vrf_banked.sv
// Directed bench for vrf_banked: element-level reference model with a read scoreboard.
module tb_vrf_banked;
  import vrf_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [1:0][2:0]            r_reg_addr;
  logic [1:0][1:0][2:0]       r_addr;
  logic [1:0][1:0][31:0]      r_data;
  logic [2:0]                 w_reg_addr;
  logic [1:0][2:0]            w_addr;
  logic [1:0][31:0]           w_data;
  logic [1:0][3:0]            w_mask;
  logic [1:0]                 w_en;
  logic                       w_ready;
  logic                       clr_v;
  logic [2:0]                 clr_reg;
  logic                       clr_ready;
  logic                       clr_done;

  typedef struct {
    int    p;
    int    l;
    elem_t exp;
  } sb_t;

  sb_t        sbq[$];
  logic [31:0] model [8][8];
  logic [1:0] rd_en;
  int         n_chk  = 0;
  int         n_fail = 0;

  vrf_banked dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .r_reg_addr_i (r_reg_addr),
    .r_addr_i     (r_addr),
    .r_data_o     (r_data),
    .w_reg_addr_i (w_reg_addr),
    .w_addr_i     (w_addr),
    .w_data_i     (w_data),
    .w_mask_i     (w_mask),
    .w_en_i       (w_en),
    .w_ready_o    (w_ready),
    .clr_v_i      (clr_v),
    .clr_reg_i    (clr_reg),
    .clr_ready_o  (clr_ready),
    .clr_done_o   (clr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_en  = 2'b00;
    clr_v = 1'b0;
    rd_en = 2'b00;
  endtask

  task automatic set_wr(input int l, input logic [2:0] elem, input logic [31:0] d, input logic [3:0] m);
    w_en[l]   = 1'b1;
    w_addr[l] = elem;
    w_data[l] = d;
    w_mask[l] = m;
  endtask

  task automatic set_rd(input int p, input logic [2:0] rg, input logic [2:0] e0, input logic [2:0] e1);
    r_reg_addr[p] = rg;
    r_addr[p][0]  = e0;
    r_addr[p][1]  = e1;
    rd_en[p]      = 1'b1;
  endtask

  // One clock: apply accepted writes to the model first (write-first), queue expected reads, compare after the edge.
  task automatic cyc(input bit acc);
    sb_t e;
    int  idx;
    if (acc) begin
      for (int l = 0; l < 2; l++) begin
        if (w_en[l]) begin
          idx = int'(w_addr[l][2:1]) * 2 + l;
          for (int b = 0; b < 4; b++) begin
            if (w_mask[l][b]) model[w_reg_addr][idx][8*b +: 8] = w_data[l][8*b +: 8];
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < 2; l++) begin
        if (rd_en[p]) begin
          e.p   = p;
          e.l   = l;
          e.exp = model[r_reg_addr[p]][int'(r_addr[p][l][2:1]) * 2 + l];
          if (!$isunknown(e.exp)) sbq.push_back(e);
        end
      end
    end
    step();
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("read p%0d l%0d", e.p, e.l), r_data[e.p][e.l], e.exp);
    end
  endtask

  task automatic fill_reg(input logic [2:0] rg, input logic [31:0] seed);
    for (int k = 0; k < 4; k++) begin
      w_reg_addr = rg;
      set_wr(0, 3'(2*k),     seed + 32'(2*k),     4'hF);
      set_wr(1, 3'(2*k + 1), seed + 32'(2*k + 1), 4'hF);
      cyc(1'b1);
    end
    idle_inputs();
  endtask

  task automatic read_reg(input logic [2:0] rg);
    set_rd(0, rg, 3'd0, 3'd1);
    set_rd(1, rg, 3'd2, 3'd3);
    cyc(1'b0);
    set_rd(0, rg, 3'd4, 3'd5);
    set_rd(1, rg, 3'd6, 3'd7);
    cyc(1'b0);
    idle_inputs();
  endtask

  task automatic zero_model(input int rg, input int lo, input int hi);
    for (int e = lo; e <= hi; e++) model[rg][e] = 32'h0;
  endtask

  task automatic wait_clr_idle(input int max_cyc);
    int n = 0;
    while (clr_ready !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk("clear idle within bound", 32'(clr_ready), 32'd1);
  endtask

  initial begin
    int low_cnt, wlow_cnt, done_cnt;
    reset      = 1'b1;
    r_reg_addr = '0;
    r_addr     = '0;
    w_reg_addr = '0;
    w_addr     = '0;
    w_data     = '0;
    w_mask     = '0;
    clr_reg    = '0;
    idle_inputs();
    step();
    step();
    chk("reset r_data p0", r_data[0][0] | r_data[0][1], 32'h0);
    chk("reset r_data p1", r_data[1][0] | r_data[1][1], 32'h0);
    chk("reset clr_ready", 32'(clr_ready), 32'd1);
    chk("reset w_ready", 32'(w_ready), 32'd1);
    chk("reset clr_done", 32'(clr_done), 32'd0);
    reset = 1'b0;
    step();

    // Basic write of reg3 elements 4/5, then both ports read them.
    w_reg_addr = 3'd3;
    set_wr(0, 3'd4, 32'hDEADBEEF, 4'hF);
    set_wr(1, 3'd5, 32'h12345678, 4'hF);
    cyc(1'b1);
    idle_inputs();
    set_rd(0, 3'd3, 3'd4, 3'd5);
    set_rd(1, 3'd3, 3'd4, 3'd5);
    cyc(1'b0);
    chk("basic p1 lane0", r_data[1][0], 32'hDEADBEEF);
    chk("basic p0 lane1", r_data[0][1], 32'h12345678);
    idle_inputs();

    // Byte-masked overwrite.
    w_reg_addr = 3'd1;
    set_wr(0, 3'd2, 32'hAABBCCDD, 4'b1111);
    cyc(1'b1);
    set_wr(0, 3'd2, 32'h11223344, 4'b0101);
    cyc(1'b1);
    idle_inputs();
    set_rd(0, 3'd1, 3'd2, 3'd3);
    cyc(1'b0);
    chk("masked merge", r_data[0][0], 32'hAA22CC44);
    idle_inputs();

    // Write-first bypass in the same cycle.
    w_reg_addr = 3'd2;
    set_wr(0, 3'd0, 32'h00000055, 4'hF);
    set_rd(1, 3'd2, 3'd0, 3'd1);
    cyc(1'b1);
    chk("bypass", r_data[1][0], 32'h00000055);
    idle_inputs();

    // Full clear of reg5; reg4 must be untouched.
    fill_reg(3'd5, 32'h50000000);
    fill_reg(3'd4, 32'h40000000);
    clr_reg  = 3'd5;
    clr_v    = 1'b1;
    low_cnt  = 0;
    wlow_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      clr_v = 1'b0;
      if (clr_ready === 1'b0) low_cnt++;
      if (w_ready === 1'b0) wlow_cnt++;
      if (clr_done === 1'b1) done_cnt++;
    end
    chk("clr_ready low cycles", 32'(low_cnt), 32'd4);
    chk("w_ready low cycles", 32'(wlow_cnt), 32'd4);
    chk("clr_done pulses", 32'(done_cnt), 32'd1);
    zero_model(5, 0, 7);
    read_reg(3'd5);
    read_reg(3'd4);

    // Write accepted alongside clr_v, then a write during CLEAR is dropped and later retried.
    fill_reg(3'd0, 32'h00C0FFEE);
    clr_reg    = 3'd6;
    clr_v      = 1'b1;
    w_reg_addr = 3'd0;
    set_wr(1, 3'd1, 32'h0BADF00D, 4'hF);
    cyc(1'b1);
    idle_inputs();
    chk("w_ready in clear", 32'(w_ready), 32'd0);
    set_wr(0, 3'd0, 32'hBAD0BAD0, 4'hF);
    cyc(1'b0);
    idle_inputs();
    wait_clr_idle(10);
    zero_model(6, 0, 7);
    set_rd(0, 3'd0, 3'd0, 3'd1);
    cyc(1'b0);
    idle_inputs();
    chk("w_ready before retry", 32'(w_ready), 32'd1);
    set_wr(0, 3'd0, 32'hBAD0BAD0, 4'hF);
    cyc(1'b1);
    idle_inputs();
    read_reg(3'd0);
    read_reg(3'd6);

    // Reset in the second CLEAR cycle: rows 0-1 cleared, rows 2-3 intact, no done pulse.
    fill_reg(3'd7, 32'h70000000);
    clr_reg = 3'd7;
    clr_v   = 1'b1;
    step();
    clr_v = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("abort clr_ready", 32'(clr_ready), 32'd1);
    chk("abort clr_done", 32'(clr_done), 32'd0);
    reset = 1'b0;
    step();
    chk("abort no late done", 32'(clr_done), 32'd0);
    zero_model(7, 0, 3);
    read_reg(3'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_banked.md
Name: vrf_banked

Overview:
- Multi-port, lane-banked vector register file; successor to the 2-read/1-write vrf.
- Generalised read-port count, per-lane byte-masked writes, registered reads with write-first bypass, and a multi-cycle register-clear engine with valid/ready handshake.
- Sits between the vector issue stage (operand reads) and the lane ALUs and load unit (writeback).

Parameters:
- els_p, 8, number of vector registers.
- vlen_p, 8, elements per register; multiple of lanes_p.
- vdw_p, 32, element width in bits; multiple of 8.
- lanes_p, 2, lanes (banks); power of two.
- read_ports_p, 2, independent read ports.
- Localparams: rows_lp = vlen_p/lanes_p, reg_aw_lp = clog2(els_p), el_aw_lp = clog2(vlen_p), mask_w_lp = vdw_p/8.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- r_reg_addr_i  in  read_ports_p x reg_aw_lp  register selected per read port.
- r_addr_i  in  read_ports_p x lanes_p x el_aw_lp  element index per port per lane.
- r_data_o  out  read_ports_p x lanes_p x vdw_p  registered read data.
- w_reg_addr_i  in  reg_aw_lp  write register (shared by all lanes).
- w_addr_i  in  lanes_p x el_aw_lp  element index per lane.
- w_data_i  in  lanes_p x vdw_p  write data.
- w_mask_i  in  lanes_p x mask_w_lp  byte enables.
- w_en_i  in  lanes_p  per-lane write enable.
- w_ready_o  out  1  writes accepted this cycle.
- clr_v_i  in  1  clear request valid.
- clr_reg_i  in  reg_aw_lp  register to clear.
- clr_ready_o  out  1  clear engine idle, can accept.
- clr_done_o  out  1  one-cycle pulse when clear completes.

Behaviour:
- One clock, clk_i. reset_i is synchronous and active-high.
- Storage: element e of register r lives in lane e%lanes_p at row e/lanes_p. The lane index comes from the port position; the low log2(lanes_p) bits of each address are ignored, and only row bits are used.
- Storage is not reset.
- Outputs on reset: r_data_o=0, clr_done_o=0, clr_ready_o=1, w_ready_o=1; FSM goes to IDLE.
- Write:
  - Lane l writes on the clock edge when w_en_i[l] && w_ready_o.
  - Only bytes with w_mask_i[l][b]=1 are updated.
  - w_en_i while w_ready_o=0 is dropped; the caller must hold the write until ready.
- Read:
  - Latency is 1 cycle. r_data_o[p][l] at cycle t+1 reflects the address at cycle t.
  - Write-first bypass: if a write to the same register and row in lane l is accepted in cycle t, the read returns the merged (post-mask) value.
  - Reads are always accepted, including during a clear.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_ready_o=1, w_ready_o=1. When clr_v_i=1, latch clr_reg_i, set row counter=0, go to CLEAR.
  - CLEAR: clr_ready_o=0, w_ready_o=0. Each cycle, write zero to row counter of the latched register in all lanes and increment the counter.
  - Leaving CLEAR: after the cycle that writes row rows_lp-1, return to IDLE and assert clr_done_o for exactly the following cycle.
  - Duration: exactly rows_lp cycles in CLEAR.
  - Reads during CLEAR see zero for rows already cleared. The bypass also applies to clear writes.
  - A clr_v_i seen in the same cycle as a w_en_i write is accepted together with it: the write completes in that cycle and CLEAR starts the next cycle.
  - reset_i during CLEAR aborts to IDLE. Rows already cleared stay zero; the remaining rows are unchanged; no clr_done_o pulse.

Decomposition:
- Package vrf_pkg: lane/row split functions, plus typedefs for element (vdw_p), byte mask, and the clear FSM state enum.
- Sub-module vrf_lane_bank: one lane's els_p x rows_lp storage with read_ports_p registered read ports, byte-masked write and bypass. Instantiate lanes_p times.
- Top level holds the clear FSM, write muxing (clear vs external) and the ready logic.

Test Plan:
- Reset, then write reg 3, elements 4 (lane0) and 5 (lane1), data 'hDEADBEEF/'h12345678, full mask. Next cycle read both ports at reg 3 → port0 and port1 both return those values one cycle later.
- Masked write 'hAABBCCDD to reg1 elem2, mask 4'b1111. Then 'h11223344 with mask 4'b0101 → read returns 'hAA22CC44.
- Bypass: same cycle, write reg2 elem0 'h55 and read port1 reg2 elem0 → r_data_o[1][0]='h55 the next cycle.
- Clear: fill reg5 with nonzero data. Pulse clr_v_i with clr_reg_i=5. Then:
  - clr_ready_o and w_ready_o are low for 4 cycles (rows_lp=4 with vlen_p=8);
  - clr_done_o pulses once;
  - all reg5 elements read 0;
  - reg4 is unchanged.
- Write during clear: assert w_en_i to reg0 while in CLEAR → write dropped. Reg0 keeps its old value; the same write retried after ready succeeds.
- Reset mid-clear: assert reset_i in the 2nd CLEAR cycle → clr_ready_o=1 the next cycle, no clr_done_o. Rows 0–1 of the target are zero; rows 2–3 keep their prior data.
